// File: rtl/apb_cmd_engine_if.sv
// APB bus bundle between the command engine (master) and NUM_SLAVES decoded slaves.
// prdata is flattened: slave k owns bits [k*DATA_W +: DATA_W].
interface apb_cmd_engine_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic [ADDR_W-1:0]            paddr;
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [DATA_W-1:0]            pwdata;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_engine.sv
// Pops command frames {op, data, addr}, runs one APB transfer per frame on the decoded
// slave and pushes a response frame {rsp_op, data, addr}; counts error responses.
module apb_cmd_engine #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 255,
    localparam int FRAME_W   = 8 + DATA_W + ADDR_W,
    localparam int SEL_W     = $clog2(NUM_SLAVES)
) (
    input  logic               clk_apb,
    input  logic               rst_apb,
    input  logic [FRAME_W-1:0] cmd_data,
    input  logic               cmd_empty,
    output logic               cmd_ren,
    output logic [FRAME_W-1:0] rsp_data,
    input  logic               rsp_full,
    output logic               rsp_wen,
    apb_cmd_engine_if.master   apb,
    input  logic               err_clr,
    output logic [15:0]        err_count,
    output logic               busy,
    output logic [1:0]         state_dbg
);
    // Handshakes: cmd_ren pops the FWFT head in the same cycle it is captured, and is
    // only high in IDLE with cmd_empty low; rsp_wen is only high in RESP with rsp_full low.
    // Both are single-cycle because the state always leaves IDLE/RESP on that edge.

    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam logic [7:0] OP_READ     = 8'h02;
    localparam logic [7:0] RSP_RD_OK   = 8'h04;
    localparam logic [7:0] RSP_WR_OK   = 8'h05;
    localparam logic [7:0] RSP_SLVERR  = 8'h06;
    localparam logic [7:0] RSP_TIMEOUT = 8'h07;
    localparam logic [7:0] RSP_ILLEGAL = 8'h08;

    // The wait counter indexes ACCESS cycles 0..TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [SEL_W-1:0]  idx_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [15:0]       err_cnt_q;

    logic [7:0]        cmd_op;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] cmd_addr;
    logic [SEL_W-1:0]  cmd_idx;
    logic              cmd_legal;
    logic              sel_ready;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic [7:0]        rsp_op;
    logic              rsp_is_err;

    assign cmd_op    = cmd_data[FRAME_W-1 -: 8];
    assign cmd_wdata = cmd_data[ADDR_W +: DATA_W];
    assign cmd_addr  = cmd_data[ADDR_W-1:0];
    assign cmd_idx   = cmd_data[ADDR_W-1 -: SEL_W];
    assign cmd_legal = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);

    // Only the addressed slave's return signals are ever looked at.
    assign sel_ready = apb.pready[idx_q];
    assign sel_err   = apb.pslverr[idx_q];
    assign sel_rdata = apb.prdata[int'(idx_q) * DATA_W +: DATA_W];

    assign rsp_op     = rsp_data[FRAME_W-1 -: 8];
    assign rsp_is_err = (rsp_op == RSP_SLVERR) || (rsp_op == RSP_TIMEOUT) || (rsp_op == RSP_ILLEGAL);

    assign cmd_ren   = !rst_apb && (state == IDLE) && !cmd_empty;
    assign rsp_wen   = !rst_apb && (state == RESP) && !rsp_full;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign err_count = err_cnt_q;

    always_ff @(posedge clk_apb) begin
        if (rst_apb) begin
            state       <= IDLE;
            addr_q      <= '0;
            idx_q       <= '0;
            wait_cnt    <= '0;
            rsp_data    <= '0;
            apb.paddr   <= '0;
            apb.psel    <= '0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.pwdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cmd_empty) begin
                        addr_q <= cmd_addr;
                        idx_q  <= cmd_idx;
                        if (cmd_legal) begin
                            apb.psel   <= NUM_SLAVES'(1) << cmd_idx;
                            apb.paddr  <= cmd_addr;
                            apb.pwrite <= (cmd_op == OP_WRITE);
                            apb.pwdata <= (cmd_op == OP_WRITE) ? cmd_wdata : '0;
                            state      <= SETUP;
                        end else begin
                            rsp_data <= {RSP_ILLEGAL, {DATA_W{1'b0}}, cmd_addr};
                            state    <= RESP;
                        end
                    end
                end
                SETUP: begin
                    apb.penable <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // pready is tested first so a ready on the last allowed cycle wins.
                    if (sel_ready) begin
                        if (sel_err)
                            rsp_data <= {RSP_SLVERR, {DATA_W{1'b0}}, addr_q};
                        else if (apb.pwrite)
                            rsp_data <= {RSP_WR_OK, apb.pwdata, addr_q};
                        else
                            rsp_data <= {RSP_RD_OK, sel_rdata, addr_q};
                        apb.psel    <= '0;
                        apb.penable <= 1'b0;
                        state       <= RESP;
                    end else if ((TIMEOUT != 0) && (wait_cnt == LAST_WAIT)) begin
                        rsp_data    <= {RSP_TIMEOUT, {DATA_W{1'b0}}, addr_q};
                        apb.psel    <= '0;
                        apb.penable <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (!rsp_full)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear has priority over a coinciding error push.
    always_ff @(posedge clk_apb) begin
        if (rst_apb || err_clr)
            err_cnt_q <= '0;
        else if (rsp_wen && rsp_is_err && (err_cnt_q != 16'hFFFF))
            err_cnt_q <= err_cnt_q + 16'd1;
    end
endmodule

// File: tb/tb_apb_cmd_engine.sv
// Directed and randomized bench for apb_cmd_engine with a FWFT command FIFO model,
// behavioural APB slaves and a response scoreboard.
module tb_apb_cmd_engine;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int NS     = 4;
    localparam int TMO    = 4;
    localparam int FW     = 8 + DATA_W + ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk_apb = 1'b0;
    logic rst_apb = 1'b1;
    always #5 clk_apb = ~clk_apb;

    logic [FW-1:0] cmd_data;
    logic          cmd_empty;
    logic          cmd_ren;
    logic [FW-1:0] rsp_data;
    logic          rsp_full;
    logic          rsp_wen;
    logic          err_clr = 1'b0;
    logic [15:0]   err_count;
    logic          busy;
    logic [1:0]    state_dbg;

    apb_cmd_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NS)) apb_bus ();

    apb_cmd_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NS), .TIMEOUT(TMO)
    ) dut (
        .clk_apb(clk_apb), .rst_apb(rst_apb),
        .cmd_data(cmd_data), .cmd_empty(cmd_empty), .cmd_ren(cmd_ren),
        .rsp_data(rsp_data), .rsp_full(rsp_full), .rsp_wen(rsp_wen),
        .apb(apb_bus),
        .err_clr(err_clr), .err_count(err_count), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- command FIFO model ----------------
    logic [FW-1:0] cmd_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    always_comb begin
        cmd_empty = (rd_ptr == wr_ptr);
        cmd_data  = cmd_empty ? '0 : cmd_mem[rd_ptr[7:0]];
    end

    // ---------------- response backpressure ----------------
    logic full_dir = 1'b0;
    logic bp_rand  = 1'b0;
    logic bp_bit   = 1'b0;
    always_comb rsp_full = bp_rand ? bp_bit : full_dir;

    // ---------------- APB slave models ----------------
    int          wait_k [NS];
    logic        err_k  [NS];
    logic [31:0] rd_val [NS];
    int          acc_cnt [NS];
    logic                 noise_en = 1'b0;
    logic [NS-1:0]        noise_rdy = '0;
    logic [NS-1:0]        noise_err = '0;
    logic [NS*DATA_W-1:0] noise_data = '0;

    initial for (int k = 0; k < NS; k++) begin
        wait_k[k] = 0; err_k[k] = 1'b0; rd_val[k] = '0; acc_cnt[k] = 0;
    end

    always_comb begin
        apb_bus.pready  = '0;
        apb_bus.pslverr = '0;
        apb_bus.prdata  = '0;
        for (int k = 0; k < NS; k++) begin
            if (apb_bus.psel[k]) begin
                apb_bus.pready[k]  = apb_bus.penable && (acc_cnt[k] >= wait_k[k]);
                apb_bus.pslverr[k] = err_k[k];
                apb_bus.prdata[k*DATA_W +: DATA_W] = rd_val[k];
            end else if (noise_en) begin
                apb_bus.pready[k]  = noise_rdy[k];
                apb_bus.pslverr[k] = noise_err[k];
                apb_bus.prdata[k*DATA_W +: DATA_W] = noise_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always @(posedge clk_apb)
        for (int k = 0; k < NS; k++)
            acc_cnt[k] <= (apb_bus.psel[k] && apb_bus.penable) ? acc_cnt[k] + 1 : 0;

    always @(negedge clk_apb) begin
        noise_rdy  = NS'($urandom);
        noise_err  = NS'($urandom);
        noise_data = {$urandom, $urandom, $urandom, $urandom};
        bp_bit     = ($urandom_range(0, 2) == 0);
    end

    // ---------------- monitor (pre-edge sampling) ----------------
    logic [FW-1:0] rsp_mem [0:255];
    int   n_rsps = 0;
    int   cyc = 0;
    int   t_ren = 0;
    int   t_wen = 0;
    int   viol = 0;
    logic prev_ren = 1'b0;
    logic prev_wen = 1'b0;

    always @(posedge clk_apb) begin
        int v;
        v = 0;
        if (!rst_apb) begin
            if (cmd_ren) begin
                rd_ptr <= rd_ptr + 1;
                t_ren  <= cyc;
            end
            if (rsp_wen) begin
                rsp_mem[n_rsps[7:0]] <= rsp_data;
                n_rsps <= n_rsps + 1;
                t_wen  <= cyc;
            end
        end
        if (cmd_ren && cmd_empty) v++;
        if (rsp_wen && rsp_full) v++;
        if (cmd_ren && prev_ren) v++;
        if (rsp_wen && prev_wen) v++;
        if (!$onehot0(apb_bus.psel)) v++;
        viol     <= viol + v;
        prev_ren <= cmd_ren;
        prev_wen <= rsp_wen;
        cyc      <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [FW-1:0] exp_q[$];
    int rsp_rd = 0;
    logic [15:0] err_model = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Response predicted from the command and the current slave behaviour.
    function automatic logic [FW-1:0] model_rsp(input logic [FW-1:0] f);
        logic [7:0]  op;
        logic [31:0] d;
        logic [15:0] a;
        int k;
        op = f[FW-1 -: 8];
        d  = f[ADDR_W +: DATA_W];
        a  = f[ADDR_W-1:0];
        k  = int'(a[15:14]);
        if (op != 8'h01 && op != 8'h02) return {8'h08, 32'h0, a};
        if (wait_k[k] >= TMO)           return {8'h07, 32'h0, a};
        if (err_k[k])                   return {8'h06, 32'h0, a};
        if (op == 8'h01)                return {8'h05, d, a};
        return {8'h04, rd_val[k], a};
    endfunction

    task automatic nxt();
        @(negedge clk_apb);
        #1;
    endtask

    task automatic push_cmd(input logic [FW-1:0] f);
        cmd_mem[wr_ptr[7:0]] = f;
        exp_q.push_back(model_rsp(f));
        wr_ptr = wr_ptr + 1;
        #1;
    endtask

    task automatic wait_ren(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (cmd_ren) seen = 1'b1;
            else nxt();
        end
        check({tag, " cmd_ren seen"}, 64'(seen), 64'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        logic [FW-1:0] obs;
        logic [FW-1:0] expv;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (rd_ptr == wr_ptr && (n_rsps - rsp_rd) == exp_q.size() && state_dbg == 2'd0)
                done = 1'b1;
            else
                nxt();
        end
        check({tag, " drained"}, 64'(done), 64'd1);
        while (rsp_rd < n_rsps) begin
            obs = rsp_mem[rsp_rd[7:0]];
            if (exp_q.size() == 0) begin
                check({tag, " response expected"}, 64'(exp_q.size()), 64'd1);
            end else begin
                expv = exp_q.pop_front();
                check({tag, " rsp"}, 64'(obs), 64'(expv));
                if (expv[FW-1 -: 8] inside {8'h06, 8'h07, 8'h08} && err_model != 16'hFFFF)
                    err_model = err_model + 16'd1;
            end
            rsp_rd++;
        end
    endtask

    task automatic randomize_slaves();
        for (int k = 0; k < NS; k++) begin
            wait_k[k] = $urandom_range(0, 5);
            err_k[k]  = ($urandom_range(0, 3) == 0);
            rd_val[k] = $urandom;
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [7:0] op;
        int r;
        r = $urandom_range(0, 4);
        if (r < 2)      op = 8'h01;
        else if (r < 4) op = 8'h02;
        else            op = 8'($urandom_range(3, 255));
        return {op, 32'($urandom), 16'($urandom)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        int n_acc;
        int pops0;
        int rsps0;
        logic [FW-1:0] f;
        logic [FW-1:0] ef;

        // Reset values
        rst_apb = 1'b1;
        repeat (3) nxt();
        check("rst psel", 64'(apb_bus.psel), 64'd0);
        check("rst penable", 64'(apb_bus.penable), 64'd0);
        check("rst paddr", 64'(apb_bus.paddr), 64'd0);
        check("rst pwdata", 64'(apb_bus.pwdata), 64'd0);
        check("rst pwrite", 64'(apb_bus.pwrite), 64'd0);
        check("rst cmd_ren", 64'(cmd_ren), 64'd0);
        check("rst rsp_wen", 64'(rsp_wen), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst err_count", 64'(err_count), 64'd0);
        check("rst rsp_data", 64'(rsp_data), 64'd0);
        check("rst state", 64'(state_dbg), 64'd0);
        rst_apb = 1'b0;
        nxt();

        // Zero-wait write to slave 1
        for (int k = 0; k < NS; k++) rd_val[k] = $urandom;
        push_cmd({8'h01, 32'hDEADBEEF, 16'h4010});
        wait_ren("wr0", 20);
        nxt();
        check("wr0 setup psel", 64'(apb_bus.psel), 64'b0010);
        check("wr0 setup penable", 64'(apb_bus.penable), 64'd0);
        check("wr0 setup bus", 64'({apb_bus.paddr, apb_bus.pwrite, apb_bus.pwdata}),
              64'({16'h4010, 1'b1, 32'hDEADBEEF}));
        nxt();
        check("wr0 access", 64'({apb_bus.psel, apb_bus.penable}), 64'({4'b0010, 1'b1}));
        nxt();
        check("wr0 rsp_wen", 64'(rsp_wen), 64'd1);
        check("wr0 rsp_data", 64'(rsp_data), 64'({8'h05, 32'hDEADBEEF, 16'h4010}));
        drain("wr0", 50);
        check("wr0 latency", 64'(t_wen - t_ren), 64'd3);

        // Read with 3 wait states from slave 3 while other slaves toggle
        noise_en  = 1'b1;
        wait_k[3] = 3;
        rd_val[3] = 32'h12345678;
        push_cmd({8'h02, 32'($urandom), 16'hC000});
        wait_ren("rd3", 20);
        nxt();
        check("rd3 setup", 64'({apb_bus.psel, apb_bus.penable}), 64'({4'b1000, 1'b0}));
        for (int a = 0; a < 4; a++) begin
            nxt();
            check("rd3 access stable",
                  64'({apb_bus.psel, apb_bus.penable, apb_bus.paddr, apb_bus.pwrite, apb_bus.pwdata, rsp_wen}),
                  64'({4'b1000, 1'b1, 16'hC000, 1'b0, 32'h0, 1'b0}));
        end
        nxt();
        check("rd3 rsp_wen", 64'(rsp_wen), 64'd1);
        check("rd3 rsp_data", 64'(rsp_data), 64'({8'h04, 32'h12345678, 16'hC000}));
        drain("rd3", 50);
        check("rd3 latency", 64'(t_wen - t_ren), 64'd6);
        wait_k[3] = 0;

        // PSLVERR write, then illegal opcode
        err_k[2] = 1'b1;
        push_cmd({8'h01, 32'($urandom), 16'h8000});
        drain("slverr", 50);
        err_k[2] = 1'b0;
        push_cmd({8'h7F, 32'($urandom), 16'h4444});
        wait_ren("illegal", 20);
        nxt();
        check("illegal no psel", 64'(apb_bus.psel), 64'd0);
        check("illegal rsp", 64'({rsp_wen, rsp_data}), 64'({1'b1, 8'h08, 32'h0, 16'h4444}));
        drain("illegal", 50);
        check("err_count after errors", 64'(err_count), 64'd2);

        // Timeout: slave never ready, then ready on the last allowed cycle
        for (int pass = 0; pass < 2; pass++) begin
            wait_k[0] = (pass == 0) ? 20 : TMO - 1;
            push_cmd({8'h01, 32'($urandom), 16'h0123});
            wait_ren("tmo", 20);
            n_acc = 0;
            for (int i = 0; i < 40; i++) begin
                nxt();
                if (rsp_wen) break;
                if (apb_bus.penable) n_acc++;
            end
            check("tmo access cycles", 64'(n_acc), 64'(TMO));
            drain("tmo", 50);
        end
        wait_k[0] = 0;
        check("err_count after timeout", 64'(err_count), 64'(err_model));

        // Response backpressure for 10 cycles
        full_dir = 1'b1;
        f = {8'h02, 32'($urandom), 16'h4ABC};
        ef = model_rsp(f);
        push_cmd(f);
        for (int i = 0; i < 30 && state_dbg != 2'd3; i++) nxt();
        for (int i = 0; i < 10; i++) begin
            nxt();
            check("bp hold", 64'({rsp_wen, rsp_data}), 64'({1'b0, ef}));
        end
        full_dir = 1'b0;
        #1;
        check("bp release rsp_wen", 64'(rsp_wen), 64'd1);
        drain("bp", 50);

        // 8 queued random commands
        randomize_slaves();
        pops0 = rd_ptr;
        rsps0 = n_rsps;
        for (int i = 0; i < 8; i++) push_cmd(rand_frame());
        drain("burst8", 400);
        check("burst8 pops", 64'(rd_ptr - pops0), 64'd8);
        check("burst8 rsps", 64'(n_rsps - rsps0), 64'd8);
        check("burst8 err_count", 64'(err_count), 64'(err_model));

        // Random rounds with random response backpressure
        bp_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            randomize_slaves();
            for (int i = 0; i < 10; i++) push_cmd(rand_frame());
            drain("rand", 1500);
            check("rand err_count", 64'(err_count), 64'(err_model));
        end
        bp_rand = 1'b0;
        for (int k = 0; k < NS; k++) begin wait_k[k] = 0; err_k[k] = 1'b0; end

        // Reset during ACCESS drops the command
        wait_k[2] = 6;
        push_cmd({8'h02, 32'($urandom), 16'h8100});
        for (int i = 0; i < 20 && !apb_bus.penable; i++) nxt();
        check("rst-mid in access", 64'(apb_bus.penable), 64'd1);
        rst_apb = 1'b1;
        nxt();
        check("rst-mid apb", 64'({apb_bus.psel, apb_bus.penable, apb_bus.paddr, apb_bus.pwrite, apb_bus.pwdata}), 64'd0);
        check("rst-mid ctl", 64'({busy, rsp_wen, cmd_ren, state_dbg}), 64'd0);
        check("rst-mid rsp_data", 64'(rsp_data), 64'd0);
        check("rst-mid err_count", 64'(err_count), 64'd0);
        void'(exp_q.pop_back());
        err_model = '0;
        rsps0 = n_rsps;
        rst_apb = 1'b0;
        repeat (10) nxt();
        check("rst-mid no response", 64'(n_rsps - rsps0), 64'd0);
        wait_k[2] = 0;

        // Error counter saturation
        force dut.err_cnt_q = 16'hFFFE;
        nxt();
        release dut.err_cnt_q;
        nxt();
        check("sat preload", 64'(err_count), 64'hFFFE);
        err_model = 16'hFFFE;
        push_cmd({8'h00, 32'($urandom), 16'h1111});
        push_cmd({8'hFF, 32'($urandom), 16'h2222});
        drain("sat", 50);
        check("sat err_count", 64'(err_count), 64'hFFFF);

        // Clear coinciding with an error push
        push_cmd({8'h7F, 32'($urandom), 16'h3333});
        wait_ren("clr", 20);
        nxt();
        err_clr = 1'b1;
        check("clr coincide rsp_wen", 64'(rsp_wen), 64'd1);
        nxt();
        err_clr = 1'b0;
        check("clr wins", 64'(err_count), 64'd0);
        drain("clr", 50);
        err_model = '0;
        check("clr err_count", 64'(err_count), 64'(err_model));

        // Global protocol invariants and FIFO balance
        check("invariant violations", 64'(viol), 64'd0);
        check("all commands popped", 64'(wr_ptr - rd_ptr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
